ps2_tx: RTL and testbench

Host-to-device PS/2 transmitter: sends one command byte (LED set 8'hED, reset 8'hFF, typematic rate, etc.) from the FPGA to the keyboard over the shared open-collector PS/2 clock and data lines. It sits beside `ps2_rx` in the keyboard path. `tx_idle` gates the receiver's `rx_en`, so `ps2_rx` never samples host-driven bits.

---
 rtl/ps2_pkg.sv | 30 +++
 rtl/ps2_line_filter.sv | 60 ++++++
 rtl/ps2_tx.sv | 194 +++++++++++++++++++
 tb/tb_ps2_tx.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ps2_pkg                                                   |
// | Purpose  : Shared PS/2 definitions: transmitter state encoding,      |
// |            frame sizes, odd-parity helper and common commands.       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RTS      = 3'd1,
        START    = 3'd2,
        DATA     = 3'd3,
        ACK      = 3'd4,
        WAIT_REL = 3'd5
    } ps2_tx_state_t;

    localparam int PS2_DATA_BITS     = 8;
    localparam int PS2_TX_SHIFT_BITS = 10;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;

    // Odd parity: the bit that makes the total count of ones odd.
    function automatic logic ps2_odd_parity(input logic [PS2_DATA_BITS-1:0] d);
        return ~^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ps2_line_filter                                           |
// | Purpose  : Two-flop synchronizer plus glitch filter for one PS/2     |
// |            line, with single-cycle fall/rise ticks on the filtered   |
// |            level. Shared by the PS/2 transmitter and receiver.       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic level,
    output logic fall_tick,
    output logic rise_tick
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          settle;

    // The level flips on the FILTER_LEN-th consecutive sample that disagrees with it.
    assign settle = (sync[1] != level) && (cnt == CW'(FILTER_LEN - 1));

    // Bring the asynchronous line into the clk domain; idle bus is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], line_in};
        end
    end

    // Count disagreeing samples, commit the new level and flag the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            level     <= 1'b1;
            cnt       <= '0;
            fall_tick <= 1'b0;
            rise_tick <= 1'b0;
        end else begin
            fall_tick <= settle & level;
            rise_tick <= settle & ~level;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (settle) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ps2_tx                                                    |
// | Purpose  : Host-to-device PS/2 transmitter. Inhibits the bus, issues |
// |            a request-to-send, shifts out one byte with odd parity    |
// |            on device clock falls and checks the device ACK.          |
// | Options  : PS2_TX_TIMEOUT_EN - watchdog on device clock activity.   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_err_tick
);

    localparam int                CNT_W    = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  RTS_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  RTS_HALF = CNT_W'(INHIBIT_CYCLES / 2);
    localparam logic [3:0]        LAST_BIT = 4'(PS2_TX_SHIFT_BITS - 1);

    ps2_tx_state_t                state, state_n;
    logic [PS2_TX_SHIFT_BITS-1:0] sreg, sreg_n;
    logic [3:0]                   bit_cnt, bit_cnt_n;
    logic [CNT_W-1:0]             cnt, cnt_n;
    logic                         ack_ok, ack_ok_n;
    logic                         data_oe, data_oe_n;
    logic                         done_n, err_n;
    logic                         c_lvl, c_fall, c_rise;
    logic                         d_lvl, d_fall, d_rise;
    logic                         wd_expired;
    logic                         unused_ok;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_c (
        .clk       (clk),
        .rst       (rst),
        .line_in   (ps2c_in),
        .level     (c_lvl),
        .fall_tick (c_fall),
        .rise_tick (c_rise)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_d (
        .clk       (clk),
        .rst       (rst),
        .line_in   (ps2d_in),
        .level     (d_lvl),
        .fall_tick (d_fall),
        .rise_tick (d_rise)
    );

    // Data-line edges are never needed; only its level is sampled.
    assign unused_ok = ^{c_rise, d_fall, d_rise, (TIMEOUT_CYCLES > 0)};

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;

    assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYCLES));

    // Cycles since the last device clock edge while the device owns the clock.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE || state == RTS || c_fall || c_rise) begin
            wd_cnt <= '0;
        end else if (!wd_expired) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign wd_expired = 1'b0;
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            sreg         <= '0;
            bit_cnt      <= '0;
            cnt          <= '0;
            ack_ok       <= 1'b0;
            data_oe      <= 1'b0;
            tx_done_tick <= 1'b0;
            tx_err_tick  <= 1'b0;
        end else begin
            state        <= state_n;
            sreg         <= sreg_n;
            bit_cnt      <= bit_cnt_n;
            cnt          <= cnt_n;
            ack_ok       <= ack_ok_n;
            data_oe      <= data_oe_n;
            tx_done_tick <= done_n;
            tx_err_tick  <= err_n;
        end
    end

    // Next-state, datapath updates and line drive.
    always_comb begin
        state_n   = state;
        sreg_n    = sreg;
        bit_cnt_n = bit_cnt;
        cnt_n     = cnt;
        ack_ok_n  = ack_ok;
        data_oe_n = data_oe;
        done_n    = 1'b0;
        err_n     = 1'b0;
        ps2c_oe   = 1'b0;
        ps2d_oe   = 1'b0;
        tx_idle   = 1'b0;

        case (state)
            IDLE: begin
                tx_idle = 1'b1;
                // A strobe coinciding with the completion pulse is dropped.
                if (wr_ps2 && !tx_done_tick && !tx_err_tick) begin
                    sreg_n    = {1'b1, ps2_odd_parity(din), din};
                    bit_cnt_n = '0;
                    cnt_n     = '0;
                    data_oe_n = 1'b0;
                    state_n   = RTS;
                end
            end
            RTS: begin
                ps2c_oe = 1'b1;
                ps2d_oe = (cnt >= RTS_HALF);
                if (cnt == RTS_LAST) begin
                    cnt_n   = '0;
                    state_n = START;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            START: begin
                ps2d_oe = 1'b1;
                // The first device fall already calls for data bit 0.
                if (c_fall) begin
                    data_oe_n = ~sreg[0];
                    sreg_n    = {1'b0, sreg[PS2_TX_SHIFT_BITS-1:1]};
                    bit_cnt_n = 4'd1;
                    state_n   = DATA;
                end
            end
            DATA: begin
                ps2d_oe = data_oe;
                if (c_fall) begin
                    data_oe_n = ~sreg[0];
                    sreg_n    = {1'b0, sreg[PS2_TX_SHIFT_BITS-1:1]};
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state_n = ACK;
                    end
                end
            end
            ACK: begin
                if (c_fall) begin
                    ack_ok_n = ~d_lvl;
                    state_n  = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (c_lvl && d_lvl) begin
                    done_n  = ack_ok;
                    err_n   = ~ack_ok;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // A silent device aborts the frame; lines release as the state leaves.
        if (wd_expired && state != IDLE && state != RTS) begin
            state_n   = IDLE;
            data_oe_n = 1'b0;
            done_n    = 1'b0;
            err_n     = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_ps2_tx                                                 |
// | Purpose  : Scoreboard bench for ps2_tx with a 10 kHz keyboard model  |
// |            (40 system clocks per device clock period).               |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_ps2_tx;
    import ps2_pkg::*;

    localparam int INHIBIT = 100;
    localparam int FLT     = 4;
    localparam int TMO     = 5000;
    localparam int HALF    = 20;

    typedef struct {
        logic [7:0] data;
        logic       parity;
        logic       ack;
        logic       has_rx;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       parity;
        logic       stop;
    } rx_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_ps2 = 1'b0;
    logic [7:0] din = 8'h00;
    logic       ps2c_in, ps2d_in;
    logic       ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_err_tick;
    logic       dev_c_low = 1'b0;
    logic       dev_d_low = 1'b0;

    exp_t exp_q[$];
    rx_t  rx_q[$];
    int   checks = 0;
    int   passes = 0;
    int   done_seen = 0;
    int   err_seen = 0;
    bit   dev_ack = 1'b1;
    bit   dev_stall = 1'b0;
    bit   dev_abort = 1'b0;
    bit   dev_busy = 1'b0;
    int   dev_bits = 0;

    // Open-collector bus: anyone pulling low wins.
    assign ps2c_in = ~(ps2c_oe | dev_c_low);
    assign ps2d_in = ~(ps2d_oe | dev_d_low);

    always #1250 clk = ~clk;

    ps2_tx #(
        .INHIBIT_CYCLES (INHIBIT),
        .FILTER_LEN     (FLT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_ps2       (wr_ps2),
        .din          (din),
        .ps2c_in      (ps2c_in),
        .ps2d_in      (ps2d_in),
        .ps2c_oe      (ps2c_oe),
        .ps2d_oe      (ps2d_oe),
        .tx_idle      (tx_idle),
        .tx_done_tick (tx_done_tick),
        .tx_err_tick  (tx_err_tick)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Keyboard side: clock 10 bits in, then clock the ACK pulse.
    task automatic device_frame();
        logic [9:0] bits;
        rx_t        r;
        bits = '0;
        for (int k = 0; k < 10; k++) begin
            if (dev_abort) break;
            dev_c_low = 1'b1;
            repeat (HALF) @(negedge clk);
            bits[k] = ps2d_in;
            dev_c_low = 1'b0;
            dev_bits = k + 1;
            repeat (HALF) @(negedge clk);
        end
        if (dev_abort) begin
            dev_c_low = 1'b0;
            dev_d_low = 1'b0;
            return;
        end
        r.data = bits[7:0];
        r.parity = bits[8];
        r.stop = bits[9];
        rx_q.push_back(r);
        dev_d_low = dev_ack;
        repeat (5) @(negedge clk);
        dev_c_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_c_low = 1'b0;
        repeat (HALF / 2) @(negedge clk);
        dev_d_low = 1'b0;
        repeat (HALF / 2) @(negedge clk);
    endtask

    // Keyboard model: wakes on a host request-to-send (clock released, data low).
    initial begin : device
        int n;
        forever begin
            @(negedge clk);
            if (!rst && !ps2c_oe && ps2d_oe) begin
                dev_busy = 1'b1;
                dev_bits = 0;
                repeat (10) @(negedge clk);
                if (dev_stall) begin
                    n = 0;
                    while (ps2d_oe && n < 20000) begin
                        @(negedge clk);
                        n++;
                    end
                end else begin
                    device_frame();
                end
                dev_busy = 1'b0;
            end
        end
    end

    // Scoreboard monitor: every completion pulse retires one expected frame.
    initial begin : monitor
        logic prev_tick;
        exp_t e;
        rx_t  r;
        prev_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_done_tick || tx_err_tick) begin
                if (tx_done_tick) done_seen++;
                else err_seen++;
                check("tick_exclusive", 32'(tx_done_tick & tx_err_tick), 0);
                check("tick_width", 32'(prev_tick), 0);
                check("idle_with_tick", 32'(tx_idle), 1);
                check("released_with_tick", 32'({ps2c_oe, ps2d_oe}), 0);
                check("tick_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("outcome_done", 32'(tx_done_tick), 32'(e.ack));
                    if (e.has_rx) begin
                        check("rx_present", 32'(rx_q.size() > 0), 1);
                        if (rx_q.size() > 0) begin
                            r = rx_q.pop_front();
                            check("rx_data", 32'(r.data), 32'(e.data));
                            check("rx_parity", 32'(r.parity), 32'(e.parity));
                            check("rx_stop", 32'(r.stop), 1);
                        end
                    end
                end
            end
            prev_tick = tx_done_tick | tx_err_tick;
        end
    end

    // Strobe a byte and check the request-to-send phase.
    task automatic send_start(input logic [7:0] b);
        int   n;
        logic d_early, d_late;
        @(posedge clk); #1;
        din = b;
        wr_ps2 = 1'b1;
        @(posedge clk); #1;
        wr_ps2 = 1'b0;
        check("strobe_c_oe", 32'(ps2c_oe), 1);
        check("strobe_idle", 32'(tx_idle), 0);
        n = 0;
        d_early = 1'b1;
        d_late = 1'b0;
        while (ps2c_oe && n < 5 * INHIBIT) begin
            if (n == INHIBIT / 2 - 1) d_early = ps2d_oe;
            if (n == INHIBIT / 2) d_late = ps2d_oe;
            n++;
            @(posedge clk); #1;
        end
        check("rts_len", 32'(n), INHIBIT);
        check("rts_d_early", 32'(d_early), 0);
        check("rts_d_late", 32'(d_late), 1);
        check("start_bit_d_oe", 32'(ps2d_oe), 1);
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        while (!(tx_idle && !dev_busy) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check("frame_finished", 32'(n < 3000), 1);
        repeat (5) @(posedge clk);
    endtask

    task automatic wait_dev_bits(input int nb);
        int n;
        n = 0;
        while (!(dev_busy && dev_bits >= nb) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check("device_progress", 32'(n < 3000), 1);
    endtask

    task automatic run_frame(input logic [7:0] b, input logic par, input logic ack);
        exp_t e;
        e.data = b;
        e.parity = par;
        e.ack = ack;
        e.has_rx = 1'b1;
        dev_ack = ack;
        exp_q.push_back(e);
        send_start(b);
        wait_frame();
    endtask

    initial begin : stim
        exp_t e;
        int   n;
        repeat (3) @(posedge clk); #1;
        check("reset_c_oe", 32'(ps2c_oe), 0);
        check("reset_d_oe", 32'(ps2d_oe), 0);
        check("reset_idle", 32'(tx_idle), 1);
        check("reset_done", 32'(tx_done_tick), 0);
        check("reset_err", 32'(tx_err_tick), 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // Hand-computed odd parity for each byte.
        run_frame(PS2_CMD_SET_LED, 1'b1, 1'b1);   // ED: six ones
        run_frame(8'h00, 1'b1, 1'b1);
        run_frame(8'h01, 1'b0, 1'b1);
        run_frame(8'h5A, 1'b1, 1'b0);              // device withholds ACK

        // Second strobe mid-frame must be dropped.
        e.data = 8'h3C; e.parity = 1'b1; e.ack = 1'b1; e.has_rx = 1'b1;
        dev_ack = 1'b1;
        exp_q.push_back(e);
        send_start(8'h3C);
        wait_dev_bits(3);
        @(posedge clk); #1;
        din = 8'hFF;
        wr_ps2 = 1'b1;
        @(posedge clk); #1;
        wr_ps2 = 1'b0;
        check("ignored_wr_no_rts", 32'(ps2c_oe), 0);
        check("ignored_wr_busy", 32'(tx_idle), 0);
        wait_frame();

        // Reset mid-frame: no response expected.
        send_start(8'hA5);
        wait_dev_bits(4);
        @(posedge clk); #1;
        rst = 1'b1;
        dev_abort = 1'b1;
        @(posedge clk); #1;
        check("midrst_c_oe", 32'(ps2c_oe), 0);
        check("midrst_d_oe", 32'(ps2d_oe), 0);
        check("midrst_idle", 32'(tx_idle), 1);
        rst = 1'b0;
        n = 0;
        while (dev_busy && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        dev_abort = 1'b0;
        repeat (20) @(posedge clk);
        run_frame(8'hF4, 1'b0, 1'b1);

`ifdef PS2_TX_TIMEOUT_EN
        // Device goes silent after the start bit.
        dev_stall = 1'b1;
        e.data = 8'h12; e.parity = 1'b1; e.ack = 1'b0; e.has_rx = 1'b0;
        exp_q.push_back(e);
        send_start(8'h12);
        n = 0;
        while (!tx_err_tick && n < 2 * TMO) begin
            @(posedge clk); #1;
            n++;
        end
        check("timeout_latency", 32'(n >= TMO && n <= TMO + 15), 1);
        check("timeout_c_oe", 32'(ps2c_oe), 0);
        check("timeout_d_oe", 32'(ps2d_oe), 0);
        wait_frame();
        dev_stall = 1'b0;
        check("err_count", 32'(err_seen), 2);
`else
        check("err_count", 32'(err_seen), 1);
`endif
        check("done_count", 32'(done_seen), 5);
        check("exp_queue_empty", 32'(exp_q.size()), 0);
        check("rx_queue_empty", 32'(rx_q.size()), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin : guard
        repeat (60000) @(posedge clk);
        $display("FAIL global_timeout: got run still active, expected finish");
        $fatal(1, "simulation did not finish");
    end

endmodule
`default_nettype wire
